bram_result_reader: RTL
=======================

BRAM_RESULT_READER -- requirements
Module: bram_result_reader

Interface
REQ-001 Parameter CNT_BIT, default 31, is the width of the word-count input and the internal word counter.
REQ-002 Parameter DWIDTH_2, default 64, is the BRAM1 data width.
REQ-003 Parameter AWIDTH, default 8, is the BRAM1 address width.
REQ-004 Parameter OUT_WIDTH, default 16, is the result lane width; DWIDTH_2 SHALL equal 4*OUT_WIDTH.
REQ-005 Port clk, input, 1, is the single clock; all logic is rising-edge.
REQ-006 Port reset_n, input, 1, is the reset; it is synchronous and active-high, so 1 = reset.
REQ-007 Port start_read_i, input, 1, is a one-cycle start pulse.
REQ-008 Port read_count_i, input, CNT_BIT, is the number of BRAM1 words to drain; it is sampled with start.
REQ-009 Port addr_b1_o, output, AWIDTH, is the BRAM1 address.
REQ-010 Port ce_b1_o, output, 1, is the BRAM1 chip enable.
REQ-011 Port we_b1_o, output, 1, is the BRAM1 write enable; it is constant 0.
REQ-012 Port q_b1_i, input, DWIDTH_2, is the BRAM1 read data, valid 1 cycle after ce.
REQ-013 Port m_valid_o, output, 1, signals that a result lane is presented.
REQ-014 Port m_ready_i, input, 1, is the downstream accept.
REQ-015 Port m_data_o, output, OUT_WIDTH, is the result lane.
REQ-016 Port m_last_o, output, 1, marks the final lane of the final word.
REQ-017 Ports idle_o, read_o and done_o, outputs, 1 each, are the state flags.

Function
REQ-018 FSM states SHALL be IDLE, REQ, CAPT, SEND and DONE.
REQ-019 IDLE: on start_read_i=1, latch read_count_i and clear word_idx and lane_idx.
  - If the count is non-zero, go to REQ.
  - If the count is zero, go to DONE.
REQ-020 REQ: drive ce_b1_o=1 and addr_b1_o=word_idx[AWIDTH-1:0] for exactly one cycle, then go to CAPT.
REQ-021 CAPT: register q_b1_i into a word buffer, then go to SEND; BRAM read latency is exactly 1 cycle.
REQ-022 SEND: m_valid_o=1 and m_data_o=buffer lane lane_idx, MSB lane first.
  - Lane 0 is [63:48], lane 1 is [47:32], lane 2 is [31:16], lane 3 is [15:0].
REQ-023 A lane transfers when m_valid_o and m_ready_i are both 1.
  - While m_ready_i=0, m_data_o and m_last_o SHALL hold stable.
  - m_valid_o SHALL not drop until the lane transfers.
REQ-024 On transfer of lane 3:
  - If word_idx = count-1, go to DONE.
  - Otherwise increment word_idx, clear lane_idx and go to REQ.
REQ-025 m_last_o=1 only while SEND, lane_idx=3 and word_idx=count-1.
REQ-026 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-027 idle_o=1 in IDLE only; read_o=1 in REQ, CAPT and SEND.
REQ-028 start_read_i outside IDLE SHALL be ignored.
REQ-029 The address SHALL wrap modulo 2^AWIDTH when the count exceeds 2^AWIDTH; the word counter stays CNT_BIT wide.
REQ-030 Steady-state timing SHALL be 6 cycles per word with m_ready_i held at 1; the first lane is valid 2 cycles after leaving IDLE.
REQ-031 ce_b1_o SHALL be 0 in every state except REQ.

Reset
REQ-032 reset_n=1 at a clock edge SHALL force IDLE and clear word_idx, lane_idx, the stored count and the buffer.
REQ-033 During and after reset, outputs SHALL be:
  - idle_o=1;
  - all other outputs 0, including m_valid_o, ce_b1_o, we_b1_o, addr_b1_o and m_data_o.
REQ-034 Reset asserted mid-transfer SHALL abort the drain without a done_o pulse; the next start begins at address 0.

Structure
REQ-035 The FSM state encoding and the lane-order constant SHALL live in a shared package used with the accessor block.
REQ-036 Lane selection SHALL be a sub-module, lane_unpacker (word plus lane_idx gives the lane), which is combinational; everything else is a single module.

Verification
REQ-037 Reset then start with count=1, BRAM1[0]=0x0001_0003_0005_0007 and ready held 1 -> lanes 0x0001, 0x0003, 0x0005, 0x0007 on consecutive cycles, m_last_o on 0x0007, and done_o one cycle later.
REQ-038 Count=4, BRAM1[k]={k,k+1,k+2,k+3} as 16-bit lanes -> 16 lanes in order, addresses 0..3 each with exactly one ce cycle, and we_b1_o always 0.
REQ-039 Count=2 with ready toggling 1,0,0,1,... -> no lane lost or duplicated, data stable during stalls, and valid never drops before transfer.
REQ-040 Start with count=0 -> no ce_b1_o and no m_valid_o; done_o pulses at cycle 1; idle_o returns at cycle 2.
REQ-041 Reset pulsed during lane 2 of word 1 of 3 -> outputs return to reset values next cycle; a subsequent start with count=1 reads address 0.
REQ-042 Count=258 with AWIDTH=8 -> words 256 and 257 read addresses 0 and 1; a start pulse sent mid-drain is ignored.

Source files
------------

// File: rtl/bram_result_reader_pkg.sv
// Shared definitions for the BRAM1 result reader.
// Holds the reader FSM state encoding and the lane-order constants used by
// both the controller and the lane unpacker.
package bram_result_reader_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StCapt = 3'd2,
    StSend = 3'd3,
    StDone = 3'd4
  } state_e;

  // Index of the final lane of a word; lanes are counted 0..LastLane.
  localparam logic [1:0] LastLane = 2'd3;

  // Lane 0 is the most significant slice of the word.
  localparam bit LaneMsbFirst = 1'b1;

endpackage

// File: rtl/bram_result_reader_lane_unpacker.sv
// Combinational lane selector: splits a buffered BRAM word into four
// OUT_WIDTH lanes and presents the one addressed by lane_idx_i.
// Ports:
//   word_i     - buffered BRAM1 word (4*OUT_WIDTH bits)
//   lane_idx_i - lane number, 0..3, in transmit order
//   lane_o     - selected lane
module lane_unpacker
  import bram_result_reader_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic [4*OUT_WIDTH-1:0] word_i,
  input  logic [1:0]             lane_idx_i,
  output logic [OUT_WIDTH-1:0]   lane_o
);

  // Physical slot counted from the LSB end of the word.
  logic [1:0] slot;

  assign slot   = LaneMsbFirst ? (LastLane - lane_idx_i) : lane_idx_i;
  assign lane_o = word_i[slot*OUT_WIDTH +: OUT_WIDTH];

endmodule

// File: rtl/bram_result_reader.sv
// BRAM1 result reader: on a start pulse, reads read_count_i words from
// BRAM1 (1-cycle read latency) and streams each word out as four
// OUT_WIDTH lanes, MSB lane first, over a valid/ready handshake.
// Ports:
//   clk, reset_n          - clock and synchronous active-high reset (1 = reset)
//   start_read_i          - one-cycle start pulse, honoured only when idle
//   read_count_i          - number of words to drain, sampled with start
//   addr_b1_o, ce_b1_o    - BRAM1 read address / chip enable
//   we_b1_o               - BRAM1 write enable, tied low
//   q_b1_i                - BRAM1 read data
//   m_valid_o, m_ready_i  - result stream handshake
//   m_data_o, m_last_o    - result lane and end-of-drain marker
//   idle_o, read_o, done_o - state flags
module bram_result_reader
  import bram_result_reader_pkg::*;
#(
  parameter int unsigned CNT_BIT   = 31,
  parameter int unsigned DWIDTH_2  = 64,
  parameter int unsigned AWIDTH    = 8,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_read_i,
  input  logic [CNT_BIT-1:0]   read_count_i,
  output logic [AWIDTH-1:0]    addr_b1_o,
  output logic                 ce_b1_o,
  output logic                 we_b1_o,
  input  logic [DWIDTH_2-1:0]  q_b1_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 m_last_o,
  output logic                 idle_o,
  output logic                 read_o,
  output logic                 done_o
);

  if (DWIDTH_2 != 4 * OUT_WIDTH) begin : g_width_check
    $error("DWIDTH_2 must equal 4*OUT_WIDTH");
  end

  state_e               state_q;
  logic [CNT_BIT-1:0]   count_q;
  logic [CNT_BIT-1:0]   word_idx_q;
  logic [1:0]           lane_idx_q;
  logic [DWIDTH_2-1:0]  buf_q;
  logic [AWIDTH-1:0]    addr_q;
  logic                 ce_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 idle_q;
  logic                 read_q;
  logic                 done_q;

  logic                 last_word;
  logic [OUT_WIDTH-1:0] lane_data;

  // Only meaningful once a non-zero count has been latched.
  assign last_word = (word_idx_q == count_q - CNT_BIT'(1));

  lane_unpacker #(
    .OUT_WIDTH (OUT_WIDTH)
  ) u_lane_unpacker (
    .word_i     (buf_q),
    .lane_idx_i (lane_idx_q),
    .lane_o     (lane_data)
  );

  // Flags are registered and updated on the same edge as the state they
  // describe. addr_q tracks the low bits of word_idx_q, so it wraps on its own.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      word_idx_q <= '0;
      lane_idx_q <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      ce_q       <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      idle_q     <= 1'b1;
      read_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_read_i) begin
            count_q    <= read_count_i;
            word_idx_q <= '0;
            lane_idx_q <= '0;
            addr_q     <= '0;
            idle_q     <= 1'b0;
            if (read_count_i != '0) begin
              state_q <= StReq;
              ce_q    <= 1'b1;
              read_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StReq: begin
          ce_q    <= 1'b0;
          state_q <= StCapt;
        end
        StCapt: begin
          buf_q   <= q_b1_i;
          valid_q <= 1'b1;
          last_q  <= 1'b0;
          state_q <= StSend;
        end
        StSend: begin
          if (m_ready_i) begin
            if (lane_idx_q == LastLane) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              if (last_word) begin
                state_q <= StDone;
                read_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                word_idx_q <= word_idx_q + 1'b1;
                lane_idx_q <= '0;
                addr_q     <= addr_q + 1'b1;
                ce_q       <= 1'b1;
                state_q    <= StReq;
              end
            end else begin
              lane_idx_q <= lane_idx_q + 2'd1;
              last_q     <= last_word && ((lane_idx_q + 2'd1) == LastLane);
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign addr_b1_o = addr_q;
  assign ce_b1_o   = ce_q;
  assign we_b1_o   = 1'b0;
  assign m_valid_o = valid_q;
  // Keep the data bus quiet when no lane is offered.
  assign m_data_o  = valid_q ? lane_data : '0;
  assign m_last_o  = last_q;
  assign idle_o    = idle_q;
  assign read_o    = read_q;
  assign done_o    = done_q;

endmodule
